// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam int unsigned DELAY_W  = 4;
  localparam int unsigned ADDR_W   = 9;
  localparam logic [ADDR_W-1:0] LEN_ZERO = 9'd256;

  // A length byte of zero encodes a full 256-byte program.
  function automatic logic [ADDR_W-1:0] decode_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? LEN_ZERO : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/prog_loader_release_timer.sv
// Loadable down-counter that times the HOLD phase before the core is released.
module release_timer
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DELAY_W-1:0] count,
  output logic               expired
);

  logic [DELAY_W-1:0] cnt_q;
  logic [DELAY_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = count;
    end else if (cnt_q != {DELAY_W{1'b0}}) begin
      cnt_d = cnt_q - DELAY_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {DELAY_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the last loaded cycle so HOLD lasts exactly `count` cycles.
  assign expired = (cnt_q == DELAY_W'(1));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: length, data bytes, optional checksum, then core release.
// Checksum support is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       restart,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       core_reset,
  output logic       done,
  output logic       error
);
  import prog_loader_pkg::*;

  localparam logic [DELAY_W-1:0] DELAY_CNT = DELAY_W'(RELEASE_DELAY);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              in_ready_q, in_ready_d;
  logic              core_reset_q, core_reset_d;
  logic              done_q, done_d;
  logic              timer_start;
  logic              timer_expired;
  logic              accept;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              error_q, error_d;
`endif

  assign accept = in_valid && in_ready_q;

  release_timer u_release_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .count   (DELAY_CNT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= {ADDR_W{1'b0}};
      addr_q       <= {ADDR_W{1'b0}};
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 8'd0;
      wr_data_q    <= 8'd0;
      in_ready_q   <= 1'b1;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= 8'd0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      in_ready_q   <= in_ready_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      error_q      <= error_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    timer_start = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = decode_len(in_data);
          addr_d  = {ADDR_W{1'b0}};
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q[7:0];
          wr_data_d = in_data;
          addr_d    = addr_q + 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d     = sum_q + in_data;
`endif
          // 9-bit compare lets a 256-byte load finish without wrapping to 0.
          if ((addr_q + 9'd1) == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d     = ST_CHECK;
`else
            state_d     = ST_HOLD;
            timer_start = 1'b1;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d     = ST_HOLD;
            timer_start = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif
      ST_HOLD: begin
        if (timer_expired) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (restart) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they register in step with it.
  always_comb begin
    in_ready_d   = 1'b0;
    core_reset_d = 1'b1;
    done_d       = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    error_d      = 1'b0;
`endif
    case (state_d)
      ST_IDLE, ST_LOAD: begin
        in_ready_d = 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        in_ready_d = 1'b1;
      end
      ST_ERROR: begin
        error_d = 1'b1;
      end
`endif
      ST_DONE: begin
        core_reset_d = 1'b0;
        done_d       = 1'b1;
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (RELEASE_DELAY = 2).
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       restart;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       core_reset;
  logic       done;
  logic       error;

  int checks = 0;
  int passed = 0;

  // {in_ready, wr_en, core_reset, done, error}
  wire [4:0] st = {in_ready, wr_en, core_reset, done, error};

  localparam logic [4:0] ST_IDLE_LOAD = 5'b10100;
  localparam logic [4:0] ST_WRITE     = 5'b11100;
  localparam logic [4:0] ST_HOLDING   = 5'b00100;
  localparam logic [4:0] ST_DONE_V    = 5'b00010;
  localparam logic [4:0] ST_ERR_V     = 5'b00101;

  always #5 clk = ~clk;

  prog_loader #(.RELEASE_DELAY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    tick();
  endtask

  task automatic wait_done(output int strays);
    strays = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      tick();
      if (wr_en === 1'b1) strays++;
    end
  endtask

  task automatic do_restart();
    in_valid = 1'b0;
    restart  = 1'b1;
    tick();
    restart  = 1'b0;
    checks++;
    if (st !== ST_IDLE_LOAD) $display("FAIL restart_idle status=%b want %b", st, ST_IDLE_LOAD);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h5A; restart = 1'b1;
    tick(); tick();
    checks++;
    if ({st, wr_addr, wr_data} !== {ST_IDLE_LOAD, 8'h00, 8'h00})
      $display("FAIL reset_hold status=%b addr=%h data=%h want %b 00 00", st, wr_addr, wr_data, ST_IDLE_LOAD);
    else passed++;
    reset = 1'b0; in_valid = 1'b0; restart = 1'b0;
    tick();
    checks++;
    if ({st, wr_addr, wr_data} !== {ST_IDLE_LOAD, 8'h00, 8'h00})
      $display("FAIL reset_after status=%b addr=%h data=%h want %b 00 00", st, wr_addr, wr_data, ST_IDLE_LOAD);
    else passed++;
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes [3];
    bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
    drive(1'b1, 8'h03);
    checks++;
    if (st !== ST_IDLE_LOAD) $display("FAIL basic_len status=%b want %b", st, ST_IDLE_LOAD);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bytes[i]);
      checks++;
`ifdef PROG_LOADER_CHECKSUM_EN
      if ({st, wr_addr, wr_data} !== {ST_WRITE, 8'(i), bytes[i]})
`else
      if ({st, wr_addr, wr_data} !== {(i == 2) ? 5'b01100 : ST_WRITE, 8'(i), bytes[i]})
`endif
        $display("FAIL basic_write%0d status=%b addr=%h data=%h want addr=%h data=%h", i, st, wr_addr, wr_data, i[7:0], bytes[i]);
      else passed++;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    drive(1'b1, 8'h16);
    checks++;
    if (st !== ST_HOLDING) $display("FAIL basic_csum status=%b want %b", st, ST_HOLDING);
    else passed++;
`endif
    drive(1'b0, 8'h00);
    checks++;
    if (st !== ST_HOLDING) $display("FAIL basic_hold2 status=%b want %b", st, ST_HOLDING);
    else passed++;
    tick();
    checks++;
    if (st !== ST_DONE_V) $display("FAIL basic_release status=%b want %b", st, ST_DONE_V);
    else passed++;
  endtask

  task automatic test_done_ignore();
    drive(1'b1, 8'h55);
    checks++;
    if (st !== ST_DONE_V) $display("FAIL done_ignore status=%b want %b", st, ST_DONE_V);
    else passed++;
    do_restart();
  endtask

  task automatic test_toggle();
    logic [7:0] bytes [4];
    int strays;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    drive(1'b1, 8'h04);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bytes[i]);
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'(i), bytes[i]})
        $display("FAIL toggle_write%0d en=%b addr=%h data=%h want 1 %h %h", i, wr_en, wr_addr, wr_data, i[7:0], bytes[i]);
      else passed++;
      if (i < 3) begin
        restart = 1'b1;
        drive(1'b0, 8'hEE);
        restart = 1'b0;
        checks++;
        if (st !== ST_IDLE_LOAD) $display("FAIL toggle_gap%0d status=%b want %b", i, st, ST_IDLE_LOAD);
        else passed++;
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    drive(1'b1, 8'hAA);
`endif
    wait_done(strays);
    checks++;
    if ({done, strays} !== {1'b1, 32'd0}) $display("FAIL toggle_done done=%b strays=%0d want 1 0", done, strays);
    else passed++;
    do_restart();
  endtask

  task automatic test_full_256();
    int strays;
    drive(1'b1, 8'h00);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i));
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'(i), 8'(i)})
        $display("FAIL full_write%0d en=%b addr=%h data=%h want 1 %h %h", i, wr_en, wr_addr, wr_data, i[7:0], i[7:0]);
      else passed++;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    drive(1'b1, 8'h80);
`endif
    wait_done(strays);
    checks++;
    if ({done, core_reset, strays} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL full_done done=%b core_reset=%b strays=%0d want 1 0 0", done, core_reset, strays);
    else passed++;
    do_restart();
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum_err();
    int strays;
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h10);
    drive(1'b1, 8'h20);
    drive(1'b1, 8'h31);
    checks++;
    if (st !== ST_ERR_V) $display("FAIL csum_error status=%b want %b", st, ST_ERR_V);
    else passed++;
    drive(1'b1, 8'h00);
    checks++;
    if (st !== ST_ERR_V) $display("FAIL csum_error_hold status=%b want %b", st, ST_ERR_V);
    else passed++;
    do_restart();
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h7E);
    drive(1'b1, 8'h7E);
    wait_done(strays);
    checks++;
    if ({done, error} !== 2'b10) $display("FAIL csum_reload done=%b error=%b want 1 0", done, error);
    else passed++;
    do_restart();
  endtask
`endif

  task automatic test_reset_mid();
    int strays;
    drive(1'b1, 8'h04);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    reset = 1'b1;
    drive(1'b1, 8'h03);
    checks++;
    if ({st, wr_addr, wr_data} !== {ST_IDLE_LOAD, 8'h00, 8'h00})
      $display("FAIL midreset status=%b addr=%h data=%h want %b 00 00", st, wr_addr, wr_data, ST_IDLE_LOAD);
    else passed++;
    reset = 1'b0;
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h7E);
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h00, 8'h7E})
      $display("FAIL midreset_reload en=%b addr=%h data=%h want 1 00 7e", wr_en, wr_addr, wr_data);
    else passed++;
`ifdef PROG_LOADER_CHECKSUM_EN
    drive(1'b1, 8'h7E);
`endif
    wait_done(strays);
    checks++;
    if ({done, strays} !== {1'b1, 32'd0}) $display("FAIL midreset_done done=%b strays=%0d want 1 0", done, strays);
    else passed++;
    do_restart();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
    test_reset();
    test_basic_load();
    test_done_ignore();
    test_toggle();
    test_full_256();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum_err();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
